// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared DS1302 constants, writer state enum and BCD check helper
// Purpose: DS1302 write command bytes, BCD time limits (shared with the rtc reader),
//          the writer FSM state type and a BCD range check function.
package rtc_pkg;

  // DS1302 write commands (register address with the write bit clear)
  localparam logic [7:0] WP_WR   = 8'h8E;
  localparam logic [7:0] SEC_WR  = 8'h80;
  localparam logic [7:0] MIN_WR  = 8'h82;
  localparam logic [7:0] HOUR_WR = 8'h84;

  // Largest legal BCD values (24h mode for hours)
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } wr_state_e;

  // True when both nibbles are decimal digits and the value does not exceed lim
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= lim);
  endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// rtl/rtc_tick_gen.sv - one-cycle enable every HALF_PERIOD clocks while enabled
// Purpose: SCLK half-period timebase, keeps the writer single-clock.
// Ports:   clk, nrst (async active-low), en_i (counter held at 0 when low),
//          tick_o (high for one cycle every HALF_PERIOD cycles of en_i).
module rtc_tick_gen #(
  parameter int HALF_PERIOD = 10
) (
  input  logic clk,
  input  logic nrst,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(HALF_PERIOD - 1);

  logic [7:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= 8'd0;
    end else if (!en_i || (cnt_q == LAST)) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/rtc_time_writer.sv
// rtl/rtc_time_writer.sv - writes BCD seconds/minutes/hours into a DS1302 over CE/SCLK/IO
// Purpose: on start, validates and latches the time, then issues four single-byte
//          writes (WP clear, seconds, minutes, hours) LSB first.
// Ports:   clk, nrst (async active-low), start, sec_bcd/min_bcd/hour_bcd (BCD time),
//          busy, done (1-cycle), err (1-cycle, invalid BCD), rtc_sclk, rtc_ce,
//          rtc_data_o/rtc_data_oe (IO drive value and enable, merged at top level).
module rtc_time_writer
  import rtc_pkg::*;
#(
  parameter int HALF_PERIOD = 10,
  parameter int GAP_HALVES  = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic [7:0] sec_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] hour_bcd,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rtc_sclk,
  output logic       rtc_ce,
  output logic       rtc_data_o,
  output logic       rtc_data_oe
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_HALVES - 1);

  wr_state_e   state_q;
  logic [1:0]  idx_q;
  logic [4:0]  half_q;
  logic [3:0]  gap_q;
  logic [15:0] shreg_q;
  logic [7:0]  sec_q, min_q, hour_q;
  logic        busy_q, done_q, err_q, sclk_q, ce_q, oe_q;
  logic        tick;

  // {data, command}; bit 0 goes out first
  function automatic logic [15:0] xfer_word(input logic [1:0] i, input logic [7:0] s,
                                            input logic [7:0] m, input logic [7:0] h);
    case (i)
      2'd0:    return {8'h00, WP_WR};
      2'd1:    return {s, SEC_WR};
      2'd2:    return {m, MIN_WR};
      default: return {h, HOUR_WR};
    endcase
  endfunction

  // The CH bit of the seconds input is not part of the time, so it is ignored by the check
  logic [7:0]  sec_masked;
  logic        in_valid;
  logic [1:0]  idx_next;
  logic [15:0] word_next;

  assign sec_masked = sec_bcd & 8'h7F;
  assign in_valid   = bcd_ok(sec_masked, SEC_MAX) && bcd_ok(min_bcd, MIN_MAX) &&
                      bcd_ok(hour_bcd, HOUR_MAX);
  assign idx_next   = idx_q + 2'd1;
  assign word_next  = xfer_word(idx_next, sec_q, min_q, hour_q);

  rtc_tick_gen #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk    (clk),
    .nrst   (nrst),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      half_q  <= 5'd0;
      gap_q   <= 4'd0;
      shreg_q <= 16'd0;
      sec_q   <= 8'd0;
      min_q   <= 8'd0;
      hour_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sclk_q  <= 1'b0;
      ce_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // done_q marks the completion cycle, in which a new start is not taken
          if (start && !done_q) begin
            if (in_valid) begin
              sec_q   <= sec_masked;
              min_q   <= {1'b0, min_bcd[6:0]};
              hour_q  <= {2'b00, hour_bcd[5:0]};
              idx_q   <= 2'd0;
              shreg_q <= xfer_word(2'd0, 8'h00, 8'h00, 8'h00);
              busy_q  <= 1'b1;
              ce_q    <= 1'b1;
              oe_q    <= 1'b1;
              sclk_q  <= 1'b0;
              state_q <= ST_SETUP;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (tick) begin
            sclk_q  <= 1'b1;
            half_q  <= 5'd0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Even halves have SCLK high; the 32nd half is the low phase after bit 15
          if (tick) begin
            if (half_q == 5'd31) begin
              state_q <= ST_HOLD;
            end else begin
              half_q <= half_q + 5'd1;
              if (!half_q[0]) begin
                sclk_q  <= 1'b0;
                // Replicating the top bit keeps bit 15 on IO through HOLD
                shreg_q <= {shreg_q[15], shreg_q[15:1]};
              end else begin
                sclk_q <= 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            ce_q  <= 1'b0;
            oe_q  <= 1'b0;
            gap_q <= 4'd0;
            if (idx_q == 2'd3) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_q == GAP_LAST) begin
              idx_q   <= idx_next;
              shreg_q <= word_next;
              ce_q    <= 1'b1;
              oe_q    <= 1'b1;
              state_q <= ST_SETUP;
            end else begin
              gap_q <= gap_q + 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rtc_sclk    = sclk_q;
  assign rtc_ce      = ce_q;
  assign rtc_data_o  = shreg_q[0];
  assign rtc_data_oe = oe_q;

endmodule

// File: tb/tb_rtc_time_writer.sv
// tb/tb_rtc_time_writer.sv - scoreboard bench for rtc_time_writer
module tb_rtc_time_writer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] sec_bcd = 8'h00;
  logic [7:0] min_bcd = 8'h00;
  logic [7:0] hour_bcd = 8'h00;
  logic       busy, done, err, rtc_sclk, rtc_ce, rtc_data_o, rtc_data_oe;

  rtc_time_writer #(.HALF_PERIOD(10), .GAP_HALVES(2)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .sec_bcd     (sec_bcd),
    .min_bcd     (min_bcd),
    .hour_bcd    (hour_bcd),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rtc_sclk    (rtc_sclk),
    .rtc_ce      (rtc_ce),
    .rtc_data_o  (rtc_data_o),
    .rtc_data_oe (rtc_data_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] exp_q[$];

  int rises = 0, ce_falls = 0, ce_bad = 0, gap_bad = 0, oe_bad = 0, stab_bad = 0;
  int ce_run = 0, gap_run = 0, bitcnt = 0;
  logic prev_sclk = 1'b0, prev_ce = 1'b0, prev_d = 1'b0;
  logic [15:0] word = 16'd0;

  task automatic monitor_loop();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        bitcnt = 0; ce_run = 0; gap_run = 0;
        prev_sclk = 1'b0; prev_ce = 1'b0; prev_d = 1'b0;
      end else begin
        if (prev_sclk && rtc_sclk && (rtc_data_o !== prev_d)) stab_bad++;
        if (rtc_data_oe && !rtc_ce) oe_bad++;
        if (!prev_sclk && rtc_sclk) begin
          rises++;
          word[bitcnt[3:0]] = rtc_data_o;
          bitcnt++;
          if (bitcnt == 16) begin
            bitcnt = 0;
            if (exp_q.size() < 2) begin
              n_cmp++; n_mis++;
              $display("FAIL io_unexpected_transfer got=%h required=none", word);
            end else begin
              e = exp_q.pop_front();
              n_cmp++;
              if (word[7:0] !== e) begin
                n_mis++;
                $display("FAIL io_cmd_byte got=%h required=%h", word[7:0], e);
              end
              e = exp_q.pop_front();
              n_cmp++;
              if (word[15:8] !== e) begin
                n_mis++;
                $display("FAIL io_data_byte got=%h required=%h", word[15:8], e);
              end
            end
          end
        end
        if (rtc_ce) ce_run++;
        if (prev_ce && !rtc_ce) begin
          ce_falls++;
          if (ce_run != 340) ce_bad++;
          ce_run = 0;
        end
        if (!rtc_ce && busy) gap_run++;
        if (!prev_ce && rtc_ce) begin
          if (gap_run != 0 && gap_run != 20) gap_bad++;
          gap_run = 0;
        end
        prev_sclk = rtc_sclk;
        prev_ce   = rtc_ce;
        prev_d    = rtc_data_o;
      end
    end
  endtask

  task automatic push_exp(input logic [7:0] es, input logic [7:0] em, input logic [7:0] eh);
    exp_q.push_back(8'h8E); exp_q.push_back(8'h00);
    exp_q.push_back(8'h80); exp_q.push_back(es);
    exp_q.push_back(8'h82); exp_q.push_back(em);
    exp_q.push_back(8'h84); exp_q.push_back(eh);
  endtask

  // Returns at 1 ns into cycle t+1, where t is the accept cycle
  task automatic do_start(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    @(negedge clk);
    sec_bcd = s; min_bcd = m; hour_bcd = h; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // lat = cycles after the accept cycle at which done is seen, 0 on timeout
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 3000; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, rtc_sclk, rtc_ce, rtc_data_o, rtc_data_oe} !== 7'b0) begin
      n_mis++;
      $display("FAIL reset_outputs got=%b required=0000000",
               {busy, done, err, rtc_sclk, rtc_ce, rtc_data_o, rtc_data_oe});
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, rtc_ce, rtc_data_oe} !== 5'b0) begin
      n_mis++;
      $display("FAIL idle_after_reset got=%b required=00000", {busy, done, err, rtc_ce, rtc_data_oe});
    end
  endtask

  task automatic run_full(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                          input logic [7:0] es, input logic [7:0] em, input logic [7:0] eh);
    int lat;
    rises = 0; ce_falls = 0;
    push_exp(es, em, eh);
    do_start(s, m, h);
    n_cmp++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      n_mis++;
      $display("FAIL busy_after_accept busy=%b err=%b required busy=1 err=0", busy, err);
    end
    wait_done(lat);
    n_cmp++;
    if (lat != 1421) begin
      n_mis++;
      $display("FAIL done_latency got=%0d required=1421", lat);
    end
    n_cmp++;
    if ({busy, rtc_ce, rtc_data_oe, err} !== 4'b0) begin
      n_mis++;
      $display("FAIL done_cycle_outputs busy/ce/oe/err=%b required=0000",
               {busy, rtc_ce, rtc_data_oe, err});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_mis++;
      $display("FAIL after_done done=%b busy=%b err=%b required 0 0 0", done, busy, err);
    end
    n_cmp++;
    if (rises != 64) begin
      n_mis++;
      $display("FAIL sclk_rises got=%0d required=64", rises);
    end
    n_cmp++;
    if (ce_falls != 4) begin
      n_mis++;
      $display("FAIL transfer_count got=%0d required=4", ce_falls);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL bytes_left got=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_invalid(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    int bad;
    bad = 0;
    do_start(s, m, h);
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL invalid_err_pulse s=%h m=%h h=%h err=%b busy=%b required err=1 busy=0",
               s, m, h, err, busy);
    end
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rtc_ce || busy || err) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_mis++;
      $display("FAIL invalid_stays_idle s=%h m=%h h=%h active_cycles=%0d required=0", s, m, h, bad);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    rises = 0;
    push_exp(8'h17, 8'h08, 8'h21);
    do_start(8'h17, 8'h08, 8'h21);
    repeat (498) @(posedge clk);
    do_start(8'h59, 8'h59, 8'h23);
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_mis++;
      $display("FAIL busy_start_ignored err=%b busy=%b required err=0 busy=1", err, busy);
    end
    wait_done(lat);
    n_cmp++;
    if (lat == 0) begin
      n_mis++;
      $display("FAIL busy_run_done got=timeout required=done");
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || rises != 64) begin
      n_mis++;
      $display("FAIL busy_run_bytes left=%0d rises=%0d required 0 and 64", exp_q.size(), rises);
      exp_q.delete();
    end
  endtask

  task automatic test_async_reset();
    int k;
    rises = 0;
    push_exp(8'h33, 8'h44, 8'h05);
    do_start(8'h33, 8'h44, 8'h05);
    k = 0;
    while (rises < 40 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    n_cmp++;
    if (rises != 40) begin
      n_mis++;
      $display("FAIL reach_bit7 rises=%0d required=40", rises);
    end
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    n_cmp++;
    if ({rtc_ce, rtc_data_oe, rtc_sclk, busy} !== 4'b0) begin
      n_mis++;
      $display("FAIL async_reset ce/oe/sclk/busy=%b required=0000",
               {rtc_ce, rtc_data_oe, rtc_sclk, busy});
    end
    repeat (3) @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, rtc_ce, done, err} !== 4'b0) begin
      n_mis++;
      $display("FAIL idle_after_release busy/ce/done/err=%b required=0000", {busy, rtc_ce, done, err});
    end
    run_full(8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03);
  endtask

  task automatic test_timing();
    n_cmp++;
    if (stab_bad != 0) begin
      n_mis++;
      $display("FAIL data_stable_sclk_high violations=%0d required=0", stab_bad);
    end
    n_cmp++;
    if (ce_bad != 0) begin
      n_mis++;
      $display("FAIL ce_width violations=%0d required=0", ce_bad);
    end
    n_cmp++;
    if (gap_bad != 0) begin
      n_mis++;
      $display("FAIL ce_gap violations=%0d required=0", gap_bad);
    end
    n_cmp++;
    if (oe_bad != 0) begin
      n_mis++;
      $display("FAIL oe_without_ce violations=%0d required=0", oe_bad);
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    run_full(8'h45, 8'h30, 8'h12, 8'h45, 8'h30, 8'h12);
    run_full(8'hD9, 8'h00, 8'h23, 8'h59, 8'h00, 8'h23);
    test_invalid(8'h10, 8'h5A, 8'h10);
    test_invalid(8'h10, 8'h20, 8'h24);
    test_ignore_busy();
    test_async_reset();
    test_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached required=finish");
    $fatal(1);
  end

endmodule

// File: doc/rtc_time_writer.md
Name: rtc_time_writer

Overview:
Writes a new time of day (BCD seconds, minutes, hours) into the DS1302 RTC over its 3-wire interface (CE, SCLK, IO). It is the write-direction counterpart of the rtc read driver, so the time can be set from buttons or a UART. The block issues four single-byte write transfers: write-protect clear, seconds, minutes, hours. IO is exposed as data/output-enable so the top level can merge it with the reader onto rtc_data_io.

Parameters:
HALF_PERIOD, 10, clk cycles per SCLK half-period (H); legal range 2..255
GAP_HALVES, 2, CE-low gap between transfers, in half-periods (G); legal range 1..15

Ports:
clk  in  1  system clock
nrst  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request to write the time; ignored while busy
sec_bcd  in  8  seconds in BCD, 0x00..0x59
min_bcd  in  8  minutes in BCD, 0x00..0x59
hour_bcd  in  8  hours in BCD, 24h format, 0x00..0x23
busy  out  1  high from accept until done
done  out  1  one-cycle pulse when all four transfers have completed
err  out  1  one-cycle pulse when start is rejected for invalid BCD
rtc_sclk  out  1  DS1302 SCLK
rtc_ce  out  1  DS1302 CE
rtc_data_o  out  1  IO drive value
rtc_data_oe  out  1  IO drive enable; top level tri-states when low

Behaviour:
- Reset (async, nrst=0): state IDLE; busy=0, done=0, err=0, rtc_sclk=0, rtc_ce=0, rtc_data_o=0, rtc_data_oe=0. CE drops immediately, even mid-transfer.
- Validation in the start cycle:
  - Each nibble must be <=9.
  - Limits: sec<=0x59, min<=0x59, hour<=0x23.
  - On failure: err=1 in the next cycle and the block stays IDLE.
  - On success: inputs are latched and later input changes have no effect.
- Latched data bytes:
  - Seconds: {1'b0, sec[6:0]}; the CH bit is cleared so the oscillator runs.
  - Minutes: {1'b0, min[6:0]}.
  - Hours: {2'b00, hour[5:0]}; bit 7 = 0 selects 24h mode.
- Transfer sequence, index 0..3 (command/data):
  - 0: 0x8E/0x00 (clear write-protect)
  - 1: 0x80/sec
  - 2: 0x82/min
  - 3: 0x84/hour
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> SETUP (next index), or HOLD -> IDLE after index 3.
- Timing: a tick generator pulses every H clk cycles while not IDLE. The accept cycle is t; cycle t+1 is the first cycle of SETUP.
  - SETUP (H cycles): ce=1, oe=1, sclk=0, data_o = bit 0 of the command.
  - SHIFT (32H cycles): 16 bits, command LSB first, then data LSB first.
    - For bit k, sclk rises at cycle t+1+(2k+1)H and falls at t+1+(2k+2)H.
    - data_o changes only at sclk falling edges (and at SETUP entry), so it is stable across each rising edge.
  - HOLD (H cycles): sclk=0, ce=1, data_o holds bit 15.
  - GAP (G·H cycles): ce=0, oe=0, sclk=0.
  - Each transfer is 34H cycles (SETUP H + SHIFT 32H + HOLD H).
- Completion:
  - done=1 and busy=0 in cycle t+1+4·34H+3·G·H. With the defaults this is t+1421.
  - ce and oe are 0 in that same cycle.
- busy is 1 from t+1 through the cycle before done.
- A start arriving while busy is ignored: no err, and the latched values are unchanged.
- A start in the same cycle as done is ignored; start is accepted only in IDLE.
- The block never reads IO; oe is never high while ce is low.

Decomposition:
- Package rtc_pkg holds:
  - DS1302 command constants: WP_WR=0x8E, SEC_WR=0x80, MIN_WR=0x82, HOUR_WR=0x84.
  - The writer state enum.
  - BCD limit constants, shared with the rtc reader.
- One sub-module, rtc_tick_gen: a counter that emits a 1-cycle enable every HALF_PERIOD cycles, held cleared when disabled. It is used instead of a divided clock so the design stays single-clock.

Test Plan:
- Reset, then start with sec=0x45, min=0x30, hour=0x12:
  - Sampling IO at each sclk rising edge yields the byte pairs 8E/00, 80/45, 82/30, 84/12, LSB first.
  - done pulses exactly at t+1421 (defaults); busy=0 and err=0 afterwards.
- sec=0xD9 (CH bit set on input): the transferred seconds byte is 0x59; hour=0x23 is accepted with bit 7 of the byte = 0.
- Invalid inputs:
  - min=0x5A: err pulses at t+1, busy stays 0, ce never rises.
  - hour=0x24: err pulses at t+1, busy stays 0, ce never rises.
- Second start at t+500 with different values: ignored, no err, and the bytes on IO match the first request.
- nrst pulled low during transfer 2, bit 7:
  - ce, oe and sclk are 0 within the same cycle (async).
  - After release the block is IDLE and a new start works normally.
- Timing checker over a full run:
  - data_o never changes while sclk=1.
  - ce is high for exactly 34H cycles per transfer, with gaps of exactly G·H cycles.
  - There are exactly 64 sclk rising edges.
